// File: rtl/seq_barrel_shifter_if.sv
// Operand/result bus for seq_barrel_shifter: start/busy/done handshake plus
// shift request fields and the registered result.
interface seq_barrel_shifter_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = 4
);
    logic             start;
    logic [1:0]       mode;
    logic [AMT_W-1:0] amount;
    logic [WIDTH-1:0] din;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] dout;
    logic             sout;

    modport master (
        output start, mode, amount, din,
        input  busy, done, dout, sout
    );

    modport slave (
        input  start, mode, amount, din,
        output busy, done, dout, sout
    );
endinterface

// File: rtl/seq_barrel_shifter.sv
// Multi-cycle shifter: one bit position per clock for a programmable amount.
// Optional feature macro SHIFT_ROTATE_EN enables rotate-left on mode 2'b11.
module seq_barrel_shifter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    seq_barrel_shifter_if.slave bus
);

    localparam logic [1:0] MODE_LSL = 2'b00;
    localparam logic [1:0] MODE_LSR = 2'b01;
    localparam logic [1:0] MODE_ASR = 2'b10;
`ifdef SHIFT_ROTATE_EN
    localparam logic [1:0] MODE_ROL = 2'b11;
`endif

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [AMT_W-1:0] cnt_q,   cnt_d;
    logic [1:0]       mode_q,  mode_d;
    logic [WIDTH-1:0] dout_q,  dout_d;
    logic             sout_q,  sout_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    logic [WIDTH-1:0] step_val;
    logic             step_bit;

    // One-position shift of the current result per latched mode; unlisted modes act as LSL.
    always_comb begin
        step_val = {dout_q[WIDTH-2:0], 1'b0};
        step_bit = dout_q[WIDTH-1];
        case (mode_q)
            MODE_LSL: begin
                step_val = {dout_q[WIDTH-2:0], 1'b0};
                step_bit = dout_q[WIDTH-1];
            end
            MODE_LSR: begin
                step_val = {1'b0, dout_q[WIDTH-1:1]};
                step_bit = dout_q[0];
            end
            MODE_ASR: begin
                step_val = {dout_q[WIDTH-1], dout_q[WIDTH-1:1]};
                step_bit = dout_q[0];
            end
`ifdef SHIFT_ROTATE_EN
            MODE_ROL: begin
                step_val = {dout_q[WIDTH-2:0], dout_q[WIDTH-1]};
                step_bit = dout_q[WIDTH-1];
            end
`endif
            default: begin
                step_val = {dout_q[WIDTH-2:0], 1'b0};
                step_bit = dout_q[WIDTH-1];
            end
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        dout_d  = dout_q;
        sout_d  = sout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    dout_d  = bus.din;
                    cnt_d   = bus.amount;
                    mode_d  = bus.mode;
                    sout_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (cnt_q != AMT_W'(0)) begin
                    dout_d = step_val;
                    sout_d = step_bit;
                    cnt_d  = cnt_q - AMT_W'(1);
                end else begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Synchronous active-low reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mode_q  <= MODE_LSL;
            dout_q  <= '0;
            sout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            dout_q  <= dout_d;
            sout_q  <= sout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.dout = dout_q;
    assign bus.sout = sout_q;

endmodule

// File: tb/tb_seq_barrel_shifter.sv
// Scoreboard bench for seq_barrel_shifter: directed requests push expected
// results; a monitor pops and checks on every done pulse.
module tb_seq_barrel_shifter;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned AMT_W = 4;

    localparam logic [1:0] LSL = 2'b00;
    localparam logic [1:0] LSR = 2'b01;
    localparam logic [1:0] ASR = 2'b10;
    localparam logic [1:0] ROL = 2'b11;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_barrel_shifter_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) bif ();

    seq_barrel_shifter #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bif)
    );

    typedef struct {
        logic [WIDTH-1:0] dout;
        logic             sout;
        int               done_cyc;
        string            name;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: sample just after each rising edge, score every done pulse.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (bif.done === 1'b1) begin
                check("done_busy_exclusive", 32'(bif.busy), 32'd0);
                if (sb.size() == 0) begin
                    check("spurious_done", 32'(bif.done), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_dout"}, 32'(bif.dout), 32'(e.dout));
                    check({e.name, "_sout"}, 32'(bif.sout), 32'(e.sout));
                    check({e.name, "_lat"},  32'(cyc),      32'(e.done_cyc));
                end
            end
        end
    end

    // Must be called at a falling edge; returns at the falling edge after acceptance.
    task automatic issue(input string name, input logic [1:0] m, input logic [AMT_W-1:0] amt,
                         input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] exp_dout,
                         input logic exp_sout);
        exp_t e;
        bif.start  = 1'b1;
        bif.mode   = m;
        bif.amount = amt;
        bif.din    = d;
        e.dout     = exp_dout;
        e.sout     = exp_sout;
        e.done_cyc = cyc + int'(amt) + 2;
        e.name     = name;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        bif.start  = 1'b0;
        bif.din    = WIDTH'($urandom);
        bif.mode   = 2'($urandom);
        bif.amount = AMT_W'($urandom);
        check({name, "_busy"}, 32'(bif.busy), 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || bif.busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(sb.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bif.start  = 1'b0;
        bif.mode   = LSL;
        bif.amount = '0;
        bif.din    = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rst_dout", 32'(bif.dout), 32'd0);
        check("rst_sout", 32'(bif.sout), 32'd0);
        check("rst_busy", 32'(bif.busy), 32'd0);
        check("rst_done", 32'(bif.done), 32'd0);

        // Basic modes
        issue("lsl81_1", LSL, 4'd1, 8'h81, 8'h02, 1'b1);
        wait_idle();
        issue("lsr90_3", LSR, 4'd3, 8'h90, 8'h12, 1'b0);
        wait_idle();
        issue("asr90_3", ASR, 4'd3, 8'h90, 8'hF2, 1'b0);
        wait_idle();

        // Zero amount, then start held during the done cycle
        issue("a5_0", LSL, 4'd0, 8'hA5, 8'hA5, 1'b0);
        @(negedge clk);
        check("b2b_done_seen", 32'(bif.done), 32'd1);
        issue("b2b_lsl2", LSL, 4'd2, 8'hA5, 8'h94, 1'b0);
        wait_idle();

        // Start while busy must be ignored
        issue("lslff_10", LSL, 4'd10, 8'hFF, 8'h00, 1'b0);
        repeat (2) @(negedge clk);
        bif.start  = 1'b1;
        bif.din    = 8'h01;
        bif.mode   = LSL;
        bif.amount = 4'd1;
        @(negedge clk);
        bif.start  = 1'b0;
        wait_idle();

        // Amounts at or beyond WIDTH
        issue("lsrff_8",  LSR, 4'd8,  8'hFF, 8'h00, 1'b1);
        wait_idle();
        issue("lsrff_9",  LSR, 4'd9,  8'hFF, 8'h00, 1'b0);
        wait_idle();
        issue("asr80_12", ASR, 4'd12, 8'h80, 8'hFF, 1'b1);
        wait_idle();
        issue("asr7f_15", ASR, 4'd15, 8'h7F, 8'h00, 1'b0);
        wait_idle();

        // Reset mid-operation: no done, outputs cleared
        bif.start  = 1'b1;
        bif.mode   = ASR;
        bif.amount = 4'd6;
        bif.din    = 8'h80;
        @(negedge clk);
        bif.start  = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_dout", 32'(bif.dout), 32'd0);
        check("midrst_busy", 32'(bif.busy), 32'd0);
        check("midrst_sout", 32'(bif.sout), 32'd0);
        check("midrst_done", 32'(bif.done), 32'd0);
        repeat (10) @(negedge clk);
        issue("post_rst_asr83_1", ASR, 4'd1, 8'h83, 8'hC1, 1'b1);
        wait_idle();

        // Mode 11: rotate when enabled, otherwise identical to LSL
`ifdef SHIFT_ROTATE_EN
        issue("m11_81_1", ROL, 4'd1, 8'h81, 8'h03, 1'b1);
        wait_idle();
        issue("m11_81_9", ROL, 4'd9, 8'h81, 8'h03, 1'b1);
        wait_idle();
`else
        issue("m11_81_1", ROL, 4'd1, 8'h81, 8'h02, 1'b1);
        wait_idle();
        issue("m11_81_9", ROL, 4'd9, 8'h81, 8'h00, 1'b0);
        wait_idle();
`endif

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
